// File: rtl/idli_uart_m.sv
// Slice-serial UART: 4-bit slice write/read port, TX byte FIFO feeding an 8N1 transmitter, single-byte receiver.
// Define IDLI_UART_PARITY_EN to insert an even-parity bit in both directions.
module idli_uart_m #(
  parameter int CLK_DIV  = 16,
  parameter int TX_DEPTH = 4
) (
  input  logic       i_uart_gck,
  input  logic       i_uart_rst,
  input  logic [1:0] i_uart_ctr,
  input  logic       i_uart_wr_en,
  input  logic       i_uart_rd_en,
  input  logic [3:0] i_uart_slice,
  output logic [3:0] o_uart_slice,
  output logic       o_uart_tx_full,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- write capture ----------------
  // The high byte of a written word is discarded, so only slices 0 and 1 are kept.
  logic       wr_busy_q;
  logic [7:0] wr_lo_q;
  logic       wr_act, push, pop, push_ok;

  assign wr_act = wr_busy_q || ((i_uart_ctr == 2'd0) && i_uart_wr_en);
  assign push   = wr_act && (i_uart_ctr == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      wr_busy_q <= 1'b0;
      wr_lo_q   <= '0;
    end else begin
      if (wr_act && !i_uart_ctr[1]) wr_lo_q[{i_uart_ctr[0], 2'b00} +: 4] <= i_uart_slice;
      wr_busy_q <= wr_act && (i_uart_ctr != 2'd3);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_q [TX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok    = push && (!fifo_full || pop);

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_uart_gck) begin
    if (push_ok) fifo_q[wr_ptr_q[AW-1:0]] <= wr_lo_q;
  end

  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_e        tx_st_q;
  logic [BW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_q, tx_end;

  assign tx_end = (tx_cnt_q == BAUD_LAST);
  assign pop    = !fifo_empty && ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && tx_end));

  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_cnt_q <= tx_end ? '0 : tx_cnt_q + 1'b1;
      case (tx_st_q)
        S_START: if (tx_end) begin
          tx_st_q  <= S_DATA;
          tx_bit_q <= '0;
          tx_q     <= tx_sh_q[0];
        end
        S_DATA: if (tx_end) begin
          if (tx_bit_q == 3'd7) begin
`ifdef IDLI_UART_PARITY_EN
            tx_st_q <= S_PARITY;
            tx_q    <= ^tx_sh_q;
`else
            tx_st_q <= S_STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= tx_sh_q[tx_bit_q + 3'd1];
          end
        end
        S_PARITY: if (tx_end) begin
          tx_st_q <= S_STOP;
          tx_q    <= 1'b1;
        end
        S_STOP: if (tx_end) tx_st_q <= S_IDLE;
        default: ;
      endcase
      // A pop (from IDLE or at the end of STOP) overrides the case above and starts a frame.
      if (pop) begin
        tx_st_q  <= S_START;
        tx_cnt_q <= '0;
        tx_sh_q  <= fifo_q[rd_ptr_q[AW-1:0]];
        tx_q     <= 1'b0;
      end
    end
  end

  // ---------------- RX FSM ----------------
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_s, rx_tick, rx_good;
  state_e        rx_st_q;
  logic [BW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
`ifdef IDLI_UART_PARITY_EN
  logic          rx_par_err_q;
`endif

  assign rx_s    = rx_sync_q[1];
  assign rx_tick = (rx_st_q == S_START) ? (rx_cnt_q == BAUD_HALF) : (rx_cnt_q == BAUD_LAST);
`ifdef IDLI_UART_PARITY_EN
  assign rx_good = (rx_st_q == S_STOP) && rx_tick && rx_s && !rx_par_err_q;
`else
  assign rx_good = (rx_st_q == S_STOP) && rx_tick && rx_s;
`endif

  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
`ifdef IDLI_UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_uart_rx};
      rx_prev_q <= rx_s;
      rx_cnt_q  <= rx_tick ? '0 : rx_cnt_q + 1'b1;
      case (rx_st_q)
        S_IDLE: if (rx_prev_q && !rx_s) begin
          rx_st_q  <= S_START;
          rx_cnt_q <= '0;
        end
        S_START: if (rx_tick) begin
          rx_st_q  <= rx_s ? S_IDLE : S_DATA;
          rx_bit_q <= '0;
        end
        S_DATA: if (rx_tick) begin
          rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
`ifdef IDLI_UART_PARITY_EN
          if (rx_bit_q == 3'd7) rx_st_q <= S_PARITY;
`else
          if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
`endif
        end
`ifdef IDLI_UART_PARITY_EN
        S_PARITY: if (rx_tick) begin
          rx_par_err_q <= (rx_s != ^rx_sh_q);
          rx_st_q      <= S_STOP;
        end
`endif
        S_STOP: if (rx_tick) rx_st_q <= S_IDLE;
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX holding / read port ----------------
  logic        rd_fire, rd_busy_q, rx_vld_q, rx_take;
  logic [15:0] rd_q;
  logic [7:0]  rx_byte_q;

  assign rd_fire = i_uart_rd_en && (i_uart_ctr == 2'd0);
  assign rx_take = rx_good && (!rx_vld_q || rd_fire);

  always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      rd_busy_q <= 1'b0;
      rd_q      <= '0;
      rx_byte_q <= '0;
      rx_vld_q  <= 1'b0;
    end else begin
      rd_busy_q <= rd_fire || (rd_busy_q && (i_uart_ctr != 2'd3));
      if (rd_fire) rd_q <= rx_vld_q ? {8'h00, rx_byte_q} : 16'h0000;
      if (rx_take) begin
        rx_byte_q <= rx_sh_q;
        rx_vld_q  <= 1'b1;
      end else if (rd_fire) begin
        rx_vld_q  <= 1'b0;
      end
    end
  end

  // Slice 0 bypasses the read register so it is available in the rd_en cycle.
  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    o_uart_slice = 4'h0;
    if (rd_fire)        o_uart_slice = rx_vld_q ? rx_byte_q[3:0] : 4'h0;
    else if (rd_busy_q) o_uart_slice = rd_q[{i_uart_ctr, 2'b00} +: 4];
  end

  assign o_uart_tx      = tx_q;
  assign o_uart_tx_full = fifo_full;
  assign o_uart_rx_vld  = rx_vld_q;
endmodule

// File: doc/idli_uart_m.md
Name: idli_uart_m

Overview:
Slice-serial UART peripheral that consumes the execute stage's 4-bit data slices and drives the top-level UART pins. Stores received bytes for the core to read back slice by slice.
- TX path: core writes a 16-bit word as four slices; the low byte is queued in a small FIFO and transmitted 8N1.
- RX path: a single-byte holding register, presented back to the core as four slices aligned to the shared 2-bit phase counter.

Parameters:
CLK_DIV, 16, gck cycles per UART bit; must be even and >= 4.
TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
i_uart_gck  input  1  core clock
i_uart_rst  input  1  asynchronous reset, active-high
i_uart_ctr  input  2  slice phase counter (0..3), slice 0 = bits [3:0]
i_uart_wr_en  input  1  write request, sampled only when ctr==0
i_uart_rd_en  input  1  read request, sampled only when ctr==0
i_uart_slice  input  4  write data slice for current ctr
o_uart_slice  output  4  read data slice for current ctr
o_uart_tx_full  output  1  TX FIFO full
o_uart_rx_vld  output  1  RX holding register holds an unread byte
i_uart_rx  input  1  UART receive pin (asynchronous)
o_uart_tx  output  1  UART transmit pin

Behaviour:
Clock and reset (already decided): one clock, i_uart_gck; reset i_uart_rst is asynchronous and active-high.

Reset values:
- o_uart_tx=1, o_uart_slice=0, o_uart_tx_full=0, o_uart_rx_vld=0.
- FIFO empty; both FSMs idle.
- Reset mid-frame aborts the frame immediately; TX line returns to 1.

Write:
- wr_en high at ctr==0 opens a 4-cycle capture; slices at ctr 0..3 fill a 16-bit shift register, LSB slice first.
- On the ctr==3 cycle, bits [7:0] are pushed into the FIFO (visible next cycle); bits [15:8] are discarded.
- If the FIFO is full at the push, the byte is dropped and the FIFO is unchanged.
- wr_en at ctr!=0 is ignored.

Read:
- rd_en at ctr==0 latches {8'h00, rx_byte} into a 16-bit read register in the same cycle and clears rx_vld at the next edge.
- o_uart_slice is combinational: read register slice indexed by ctr. Slice 0 (ctr==0) equals rx_byte[3:0] in the same cycle as rd_en.
- o_uart_slice is 0 outside an active read window.
- rd_en while rx_vld=0 returns 16'h0000.

TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE.
- Each state lasts CLK_DIV cycles, counted by a baud counter that reloads on every state change.
- IDLE pops the FIFO when it is non-empty; START begins the cycle after the pop.
- Back-to-back bytes: STOP goes directly to START when the FIFO is non-empty, with no extra idle bit.
- Simultaneous push and pop on a full FIFO: the pop wins first, so the push is accepted.

RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- i_uart_rx passes through a 2-flop synchronizer, reset to 1.
- A falling edge in IDLE starts the counter; the start bit is sampled at CLK_DIV/2. If the sample is 1, the FSM returns to IDLE (glitch rejection).
- Data bits are sampled every CLK_DIV cycles thereafter.
- Stop bit sampled as 0 = framing error: the byte is discarded.
- Valid byte with rx_vld=0: written to rx_byte, rx_vld set.
- Valid byte with rx_vld=1: the new byte is dropped and the old byte is retained (overrun).
- A byte completing in the same cycle as the rx_vld clear from a read is accepted.

Widths: baud counter is $clog2(CLK_DIV) bits; FIFO pointers are $clog2(TX_DEPTH)+1 bits, with the wrap bit used for full/empty.

Optional Feature:
IDLI_UART_PARITY_EN:
- Defined: a PARITY state is inserted after DATA in both FSMs. TX sends even parity (XOR of the 8 data bits). RX discards the byte on a parity mismatch, same as a framing error.
- Undefined: no parity state; the frame is 10 bits (8N1).

Test Plan:
All scenarios use CLK_DIV=4 and TX_DEPTH=4 unless stated.
- Write 16'hA5C3 at ctr==0 -> tx is 0 for 4 cycles, then bits 1,1,0,0,0,0,1,1 (0xC3 LSB first, 4 cycles each), then 1 for 4 cycles; the 0xA5 high byte is never sent.
- Five back-to-back writes while the line is busy -> tx_full=1 after the 4th queued byte; the 5th byte is dropped; exactly 4 frames emitted contiguously with no idle gap.
- Drive an RX frame carrying 0x3C -> rx_vld=1 after the stop bit. rd_en at ctr==0 -> o_uart_slice = C, 3, 0, 0 over ctr 0..3; rx_vld=0 afterwards.
- RX 0x11, then RX 0x22 without a read -> read returns 0x0011 (overrun drop). A second frame with stop bit 0 -> rx_vld unchanged.
- 1-cycle low glitch on rx in IDLE -> no byte received. Assert i_uart_rst mid-TX-frame -> tx=1 on the same edge, FIFO empty.
- With IDLI_UART_PARITY_EN: TX of 0x07 sends parity bit 1; an RX frame carrying 0x07 with parity 0 -> byte discarded, rx_vld stays 0.
